// File: rtl/seg7_capture_pkg.sv
// Shared 7-segment definitions: hex-to-segment table and blank pattern.
// Both the forward encoder and the capture decoder read this table.
package seg7_capture_pkg;

  localparam logic [6:0] BLANK = 7'b0000000;

  // Segment patterns, gfedcba, indexed by nibble value.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1110001,
    7'b1111001,
    7'b1011110,
    7'b0111001,
    7'b1111100,
    7'b1110111,
    7'b1101111,
    7'b1111111,
    7'b0000111,
    7'b1111101,
    7'b1101101,
    7'b1100110,
    7'b1001111,
    7'b1011011,
    7'b0000110,
    7'b0111111
  };

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    return SEG_TABLE[n];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to nibble decoder.
// hit is low when the pattern is not a hex glyph.
module seg7_decode
  import seg7_capture_pkg::*;
(
  input  logic [6:0] pat,
  output logic       hit,
  output logic [3:0] nibble
);

  // Search the shared table for the pattern.
  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_TABLE[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Multiplexed 7-segment bus receiver: filters, decodes and assembles
// NDIG digits into a frame presented on a valid/ready output.
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int NDIG       = 2,
  parameter int STABLE     = 3,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  input  logic              seg_vld,
  output logic [4*NDIG-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_pulse
);

  localparam int CW = 4;

  logic [6:0]            pat;
  logic                  one_hot;
  logic                  smp_ok;
  logic                  same;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [NDIG-1:0]       prev_sel;
  logic [6:0]            prev_pat;
  logic                  acc;
  logic                  hit;
  logic [3:0]            nibble;
  logic                  store;
  logic                  bad;
  logic [NDIG-1:0]       mask;
  logic [NDIG-1:0]       mask_nxt;
  logic [NDIG-1:0][3:0]  slots;
  logic [NDIG-1:0][3:0]  slots_nxt;
  logic                  load;

  assign pat     = ACTIVE_LOW ? ~seg_in : seg_in;
  assign one_hot = (dig_sel != '0) &&
                   ((dig_sel & (dig_sel - NDIG'(1))) == '0);
  assign smp_ok  = seg_vld && one_hot;

  seg7_decode u_dec (
    .pat    (pat),
    .hit    (hit),
    .nibble (nibble)
  );

  // Stability filter: count identical samples, accept once per run.
  always_comb begin
    same    = (cnt != '0) && (dig_sel == prev_sel) &&
              (pat == prev_pat);
    cnt_nxt = '0;
    acc     = 1'b0;
    if (smp_ok) begin
      if (same) begin
        cnt_nxt = (cnt == CW'(STABLE)) ? cnt : cnt + 1'b1;
        acc     = (cnt == CW'(STABLE - 1));
      end else begin
        cnt_nxt = CW'(1);
        acc     = (STABLE == 1);
      end
    end
    store = acc && hit;
    bad   = acc && !hit && (pat != BLANK);
  end

  // Slot/mask update and frame transfer decision.
  always_comb begin
    slots_nxt = slots;
    for (int i = 0; i < NDIG; i++) begin
      if (store && dig_sel[i]) slots_nxt[i] = nibble;
    end
    load     = (&mask) && (!out_valid || out_ready);
    mask_nxt = load ? '0 : (mask | (store ? dig_sel : '0));
  end

  // Filter state: run counter and the sample it refers to.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      prev_sel <= '0;
      prev_pat <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (smp_ok && !same) begin
        prev_sel <= dig_sel;
        prev_pat <= pat;
      end
    end
  end

  // Capture slots and the mask of digits received this frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '0;
      mask  <= '0;
    end else begin
      slots <= slots_nxt;
      mask  <= mask_nxt;
    end
  end

  // Output register, handshake and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= bad;
      if (load) begin
        out_data  <= slots_nxt;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized self-checking bench for seg7_capture with a
// run-length behavioural model of the receive path.
module tb_seg7_capture;

  localparam int NDIG       = 2;
  localparam int STABLE     = 3;
  localparam bit ACTIVE_LOW = 1'b1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [6:0]        seg_in = 7'h7f;
  logic [NDIG-1:0]   dig_sel = '0;
  logic              seg_vld = 1'b0;
  logic              out_ready = 1'b0;
  logic [4*NDIG-1:0] out_data;
  logic              out_valid;
  logic              err_pulse;

  seg7_capture #(
    .NDIG       (NDIG),
    .STABLE     (STABLE),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .seg_vld   (seg_vld),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] tbl [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  int                run;
  logic [NDIG-1:0]   l_sel;
  logic [6:0]        l_pat;
  logic [3:0]        m_slot [NDIG];
  logic [NDIG-1:0]   m_mask;
  logic              m_ov;
  logic [4*NDIG-1:0] m_data;
  logic              m_err;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [6:0] p;
    bit v, acc, ld;
    int hitn, d;
    if (rst) begin
      run = 0; l_sel = '0; l_pat = '0;
      m_mask = '0; m_ov = 0; m_data = '0; m_err = 0;
      for (int i = 0; i < NDIG; i++) m_slot[i] = 4'h0;
      return;
    end
    p = ACTIVE_LOW ? ~seg_in : seg_in;
    v = seg_vld && ($countones(dig_sel) == 1);
    if (!v) run = 0;
    else if (run > 0 && dig_sel == l_sel && p == l_pat) run++;
    else begin
      run = 1; l_sel = dig_sel; l_pat = p;
    end
    acc = v && (run == STABLE);
    hitn = -1;
    for (int k = 0; k < 16; k++) if (tbl[k] == p) hitn = k;
    d = 0;
    for (int i = 0; i < NDIG; i++) if (dig_sel[i]) d = i;
    m_err = acc && hitn < 0 && p != 7'h00;
    ld = (m_mask == '1) && (!m_ov || out_ready);
    if (acc && hitn >= 0) m_slot[d] = hitn[3:0];
    if (ld) begin
      for (int i = 0; i < NDIG; i++) m_data[4*i +: 4] = m_slot[i];
      m_ov = 1;
      m_mask = '0;
    end else begin
      if (out_ready) m_ov = 0;
      if (acc && hitn >= 0) m_mask[d] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("valid", 32'(out_valid), 32'(m_ov));
    check("data", 32'(out_data), 32'(m_data));
    check("err", 32'(err_pulse), 32'(m_err));
  endtask

  task automatic drive(logic [NDIG-1:0] sel, logic [6:0] p, int n);
    seg_vld = 1'b1;
    dig_sel = sel;
    seg_in = ACTIVE_LOW ? ~p : p;
    repeat (n) step();
  endtask

  task automatic idle(int n);
    seg_vld = 1'b0;
    dig_sel = '0;
    seg_in = ACTIVE_LOW ? 7'h7f : 7'h00;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [NDIG-1:0] sel;
    logic [6:0] p;
    int n;

    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_err", 32'(err_pulse), 0);
    check("rst_data", 32'(out_data), 0);

    out_ready = 0;
    drive(2'b01, 7'b1011011, 3);
    drive(2'b10, 7'b1111001, 3);
    check("basic_lat", 32'(out_valid), 0);
    drive(2'b10, 7'b1111001, 1);
    check("basic_valid", 32'(out_valid), 1);
    check("basic_data", 32'(out_data), 'hE2);
    out_ready = 1;
    drive(2'b10, 7'b1111001, 4);
    check("basic_once", 32'(out_valid), 0);

    do_reset();
    out_ready = 0;
    drive(2'b01, 7'b1011011, 2);
    drive(2'b01, 7'b1001111, 1);
    drive(2'b01, 7'b0000110, 3);
    drive(2'b10, 7'b0111111, 3);
    idle(1);
    check("glitch_valid", 32'(out_valid), 1);
    check("glitch_data", 32'(out_data), 'h01);

    do_reset();
    drive(2'b01, 7'b1010101, 3);
    check("bad_err", 32'(err_pulse), 1);
    idle(1);
    check("bad_once", 32'(err_pulse), 0);
    drive(2'b01, 7'b0000000, 3);
    check("blank_err", 32'(err_pulse), 0);
    drive(2'b10, 7'b1101101, 3);
    idle(2);
    check("bad_nomask", 32'(out_valid), 0);

    do_reset();
    out_ready = 0;
    drive(2'b01, 7'b1011011, 3);
    drive(2'b10, 7'b1100110, 3);
    idle(1);
    check("bp_first", 32'(out_data), 'h42);
    drive(2'b01, 7'b0111001, 3);
    drive(2'b10, 7'b0000111, 3);
    idle(2);
    check("bp_hold", 32'(out_data), 'h42);
    check("bp_hold_v", 32'(out_valid), 1);
    out_ready = 1;
    idle(1);
    check("bp_reload_v", 32'(out_valid), 1);
    check("bp_reload", 32'(out_data), 'h7C);
    idle(1);
    check("bp_drain", 32'(out_valid), 0);
    out_ready = 0;

    do_reset();
    drive(2'b11, 7'b1001111, 5);
    check("strobe_err", 32'(err_pulse), 0);
    drive(2'b10, 7'b1101111, 3);
    idle(2);
    check("strobe_nofr", 32'(out_valid), 0);

    do_reset();
    drive(2'b01, 7'b1011011, 3);
    drive(2'b10, 7'b1100110, 3);
    idle(1);
    rst = 1;
    idle(1);
    rst = 0;
    check("rst_hs", 32'(out_valid), 0);
    drive(2'b01, 7'b1001111, 3);
    rst = 1;
    idle(1);
    rst = 0;
    drive(2'b10, 7'b1101111, 3);
    idle(2);
    check("rst_lost", 32'(out_valid), 0);

    for (int it = 0; it < 2500; it++) begin
      case ($urandom_range(0, 9))
        0: sel = NDIG'($urandom_range(0, 3));
        default: sel = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      endcase
      case ($urandom_range(0, 9))
        0: p = 7'($urandom);
        1: p = 7'h00;
        default: p = tbl[$urandom_range(0, 15)];
      endcase
      n = $urandom_range(1, 5);
      seg_vld = ($urandom_range(0, 9) != 0);
      dig_sel = sel;
      seg_in = ACTIVE_LOW ? ~p : p;
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < n; k++) begin
        out_ready = ($urandom_range(0, 2) == 0);
        step();
      end
      rst = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
